writeback_arbiter: RTL and testbench

- Producer side of the 4x16-bit register file write port (RD / WriteData / RegWrite).
- Merges two result sources onto the single write port: single-cycle ALU results and variable-latency memory load returns.
- Load returns are buffered in a small FIFO.
- Keeps a per-register Busy scoreboard that the decoder uses to stall on outstanding loads.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_load_fifo.sv | 56 +++++
 rtl/writeback_arbiter.sv | 153 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback path.
package wb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned CNT_W    = 3;  // holds 0..4, the largest legal FIFO depth

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] rd);
    reg_onehot = NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small circular FIFO that buffers load returns which lost arbitration.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage is never reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and buffered load returns onto the register-file write port,
// with a Busy scoreboard and ALU starvation stall. Define WB_STATS_EN for commit counters.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                AluValid,
  input  logic [ADDR_W-1:0]   AluRD,
  input  logic [DATA_W-1:0]   AluData,
  input  logic                LdIssue,
  input  logic [ADDR_W-1:0]   LdIssueRD,
  input  logic                MemValid,
  input  logic [ADDR_W-1:0]   MemRD,
  input  logic [DATA_W-1:0]   MemData,
  output logic                MemReady,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   RD,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] Busy,
  output logic                AluStall
`ifdef WB_STATS_EN
  ,
  output logic [15:0]         AluWbCount,
  output logic [15:0]         MemWbCount
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

  wb_entry_t           mem_entry;
  wb_entry_t           fifo_head;
  wb_entry_t           sel_entry;
  wb_src_e             sel_src;
  wb_src_e             wb_src;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                mem_accept;
  logic                bypass;
  logic [3:0]          starve_cnt;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  assign mem_entry  = '{rd: MemRD, data: MemData};
  assign MemReady   = !Reset && (fifo_count < DEPTH_CNT);
  assign mem_accept = MemValid && MemReady;
  assign AluStall   = (starve_cnt == STARVE_MAX);

  wb_load_fifo #(.DEPTH(DEPTH)) u_load_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push       (fifo_push),
    .push_entry (mem_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_src   = SRC_NONE;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    if (AluValid) begin
      sel_src   = SRC_ALU;
      sel_entry = '{rd: AluRD, data: AluData};
    end else if (!fifo_empty) begin
      sel_src   = SRC_MEM;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
    end else if (mem_accept) begin
      sel_src   = SRC_MEM;
      sel_entry = mem_entry;
      bypass    = 1'b1;
    end
    fifo_push = mem_accept && !bypass;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
      wb_src    <= SRC_NONE;
    end else begin
      RegWrite <= (sel_src != SRC_NONE);
      wb_src   <= sel_src;
      if (sel_src != SRC_NONE) begin
        RD        <= sel_entry.rd;
        WriteData <= sel_entry.data;
      end
    end
  end

  // A load's Busy bit drops at the end of the cycle its data is on the write port.
  assign busy_set = LdIssue ? reg_onehot(LdIssueRD) : '0;
  assign busy_clr = (RegWrite && wb_src == SRC_MEM) ? reg_onehot(RD) : '0;

  always_ff @(posedge Clock) begin
    if (Reset) Busy <= '0;
    else       Busy <= (Busy & ~busy_clr) | busy_set;
  end

  always_ff @(posedge Clock) begin
    if (Reset)                                       starve_cnt <= '0;
    else if (fifo_pop)                               starve_cnt <= '0;
    else if (AluValid && !fifo_empty && !AluStall)   starve_cnt <= starve_cnt + 4'd1;
  end

`ifdef WB_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      AluWbCount <= '0;
      MemWbCount <= '0;
    end else if (RegWrite) begin
      if (wb_src == SRC_ALU) AluWbCount <= AluWbCount + 16'd1;
      if (wb_src == SRC_MEM) MemWbCount <= MemWbCount + 16'd1;
    end
  end
`endif

  // A register whose load commits this cycle is no longer outstanding for reissue or ALU use.
  a_issue_busy: assert property (@(posedge Clock) disable iff (Reset)
    !(LdIssue && Busy[LdIssueRD] && !busy_clr[LdIssueRD]))
    else $error("load issued to busy register %0d", LdIssueRD);

  a_alu_busy: assert property (@(posedge Clock) disable iff (Reset)
    !(AluValid && Busy[AluRD] && !busy_clr[AluRD]))
    else $error("alu write to busy register %0d", AluRD);

  a_mem_not_busy: assert property (@(posedge Clock) disable iff (Reset)
    !(MemValid && !Busy[MemRD]))
    else $error("load return to idle register %0d", MemRD);

  a_alu_during_stall: assert property (@(posedge Clock) disable iff (Reset)
    !(AluValid && AluStall))
    else $error("alu result presented during stall");

  a_push_when_full: assert property (@(posedge Clock) disable iff (Reset)
    !(fifo_push && fifo_full && !fifo_pop))
    else $error("push into full load fifo");

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected writes are queued at stimulus time
// and compared by a monitor whenever RegWrite is high.
module tb_writeback_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        AluValid;
  logic [1:0]  AluRD;
  logic [15:0] AluData;
  logic        LdIssue;
  logic [1:0]  LdIssueRD;
  logic        MemValid;
  logic [1:0]  MemRD;
  logic [15:0] MemData;
  logic        MemReady;
  logic        RegWrite;
  logic [1:0]  RD;
  logic [15:0] WriteData;
  logic [3:0]  Busy;
  logic        AluStall;
`ifdef WB_STATS_EN
  logic [15:0] AluWbCount;
  logic [15:0] MemWbCount;
`endif

  typedef struct packed {
    logic [1:0]  rd;
    logic [15:0] data;
    logic        mem;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_alu_exp   = 0;
  int   n_mem_exp   = 0;

  writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .AluValid  (AluValid),
    .AluRD     (AluRD),
    .AluData   (AluData),
    .LdIssue   (LdIssue),
    .LdIssueRD (LdIssueRD),
    .MemValid  (MemValid),
    .MemRD     (MemRD),
    .MemData   (MemData),
    .MemReady  (MemReady),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData),
    .Busy      (Busy),
    .AluStall  (AluStall)
`ifdef WB_STATS_EN
    ,
    .AluWbCount(AluWbCount),
    .MemWbCount(MemWbCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Mid-cycle monitor: every presented write must match the oldest expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (RegWrite === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", RD, WriteData);
      end else begin
        e = exp_q.pop_front();
        if (RD !== e.rd || WriteData !== e.data) begin
          miscompares++;
          $display("FAIL write_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   RD, WriteData, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle;
    AluValid = 1'b0; AluRD = '0; AluData = '0;
    LdIssue = 1'b0; LdIssueRD = '0;
    MemValid = 1'b0; MemRD = '0; MemData = '0;
  endtask

  task automatic expect_write(input logic [1:0] rd, input logic [15:0] data, input logic mem);
    exp_q.push_back('{rd: rd, data: data, mem: mem});
    if (mem) n_mem_exp++;
    else     n_alu_exp++;
  endtask

  task automatic test_reset;
    Reset = 1'b1; MemValid = 1'b1; MemRD = 2'd0; MemData = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++; if (MemReady !== 1'b0) begin miscompares++; $display("FAIL reset_memready: got %b required 0", MemReady); end
      vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite: got %b required 0", RegWrite); end
    end
    Reset = 1'b0; MemValid = 1'b0;
    #1;
    vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL release_memready: got %b required 1", MemReady); end
    vectors++; if (Busy !== 4'b0000) begin miscompares++; $display("FAIL release_busy: got %b required 0000", Busy); end
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL release_regwrite: got %b required 0", RegWrite); end
    vectors++; if (RD !== 2'd0 || WriteData !== 16'h0) begin miscompares++; $display("FAIL release_port: got rd=%0d data=%h required 0/0000", RD, WriteData); end
    vectors++; if (AluStall !== 1'b0) begin miscompares++; $display("FAIL release_stall: got %b required 0", AluStall); end
  endtask

  task automatic test_alu_path;
    idle();
    AluValid = 1'b1; AluRD = 2'd2; AluData = 16'h1234;
    expect_write(2'd2, 16'h1234, 1'b0);
    tick;
    AluValid = 1'b0;
    vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL alu_regwrite: got %b required 1", RegWrite); end
    vectors++; if (RD !== 2'd2) begin miscompares++; $display("FAIL alu_rd: got %0d required 2", RD); end
    vectors++; if (WriteData !== 16'h1234) begin miscompares++; $display("FAIL alu_data: got %h required 1234", WriteData); end
    tick;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL alu_idle: got %b required 0", RegWrite); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    idle();
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      AluValid = 1'b1; AluRD = i[1:0]; AluData = d;
      expect_write(i[1:0], d, 1'b0);
      tick;
    end
    AluValid = 1'b0;
    vectors++; if (RegWrite !== 1'b1 || RD !== 2'd3) begin miscompares++; $display("FAIL b2b_last: got we=%b rd=%0d required 1/3", RegWrite, RD); end
    tick;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b required 0", RegWrite); end
  endtask

  task automatic test_load_bypass;
    idle();
    LdIssue = 1'b1; LdIssueRD = 2'd1;
    tick;
    LdIssue = 1'b0;
    vectors++; if (Busy !== 4'b0010) begin miscompares++; $display("FAIL bypass_busy_set: got %b required 0010", Busy); end
    tick;
    MemValid = 1'b1; MemRD = 2'd1; MemData = 16'hBEEF;
    expect_write(2'd1, 16'hBEEF, 1'b1);
    #1;
    vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL bypass_ready: got %b required 1", MemReady); end
    tick;
    MemValid = 1'b0;
    vectors++; if (RegWrite !== 1'b1 || RD !== 2'd1 || WriteData !== 16'hBEEF) begin miscompares++; $display("FAIL bypass_write: got we=%b rd=%0d data=%h required 1/1/beef", RegWrite, RD, WriteData); end
    vectors++; if (Busy !== 4'b0010) begin miscompares++; $display("FAIL bypass_busy_hold: got %b required 0010", Busy); end
    tick;
    vectors++; if (Busy !== 4'b0000) begin miscompares++; $display("FAIL bypass_busy_clr: got %b required 0000", Busy); end
  endtask

  task automatic test_fifo_fill;
    logic [1:0] ld_rd [3];
    logic       want_rdy;
    ld_rd[0] = 2'd0; ld_rd[1] = 2'd1; ld_rd[2] = 2'd3;
    idle();
    for (int i = 0; i < 3; i++) begin
      LdIssue = 1'b1; LdIssueRD = ld_rd[i];
      tick;
    end
    LdIssue = 1'b0;
    vectors++; if (Busy !== 4'b1011) begin miscompares++; $display("FAIL fill_busy: got %b required 1011", Busy); end
    AluValid = 1'b1; AluRD = 2'd2;
    for (int i = 0; i < 3; i++) begin
      AluData = 16'hC000 + 16'(i);
      expect_write(2'd2, AluData, 1'b0);
      MemValid = 1'b1; MemRD = ld_rd[i]; MemData = 16'hA000 + 16'(i);
      want_rdy = (i < 2);
      #1;
      vectors++; if (MemReady !== want_rdy) begin miscompares++; $display("FAIL fill_ready_%0d: got %b required %b", i, MemReady, want_rdy); end
      tick;
    end
    AluValid = 1'b0;
    for (int i = 0; i < 3; i++) expect_write(ld_rd[i], 16'hA000 + 16'(i), 1'b1);
    #1;
    vectors++; if (MemReady !== 1'b0) begin miscompares++; $display("FAIL fill_full: got %b required 0", MemReady); end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i == 0) begin
        vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL fill_ready_again: got %b required 1", MemReady); end
      end
      if (i == 1) MemValid = 1'b0;
      vectors++; if (RegWrite !== 1'b1 || RD !== ld_rd[i]) begin miscompares++; $display("FAIL fill_order_%0d: got we=%b rd=%0d required 1/%0d", i, RegWrite, RD, ld_rd[i]); end
    end
    tick;
    vectors++; if (RegWrite !== 1'b0 || Busy !== 4'b0000) begin miscompares++; $display("FAIL fill_drain: got we=%b busy=%b required 0/0000", RegWrite, Busy); end
  endtask

  task automatic test_starvation;
    idle();
    LdIssue = 1'b1; LdIssueRD = 2'd2;
    tick;
    LdIssue = 1'b0;
    AluValid = 1'b1; AluRD = 2'd0; AluData = 16'h0100;
    expect_write(2'd0, 16'h0100, 1'b0);
    MemValid = 1'b1; MemRD = 2'd2; MemData = 16'h5A5A;
    tick;
    MemValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (AluStall !== 1'b0) begin miscompares++; $display("FAIL starve_early_%0d: got %b required 0", k, AluStall); end
      AluData = 16'h0100 + 16'(k);
      expect_write(2'd0, AluData, 1'b0);
      tick;
    end
    vectors++; if (AluStall !== 1'b1) begin miscompares++; $display("FAIL starve_stall: got %b required 1", AluStall); end
    AluValid = 1'b0;
    expect_write(2'd2, 16'h5A5A, 1'b1);
    tick;
    vectors++; if (AluStall !== 1'b0) begin miscompares++; $display("FAIL starve_release: got %b required 0", AluStall); end
    vectors++; if (RegWrite !== 1'b1 || RD !== 2'd2 || WriteData !== 16'h5A5A) begin miscompares++; $display("FAIL starve_write: got we=%b rd=%0d data=%h required 1/2/5a5a", RegWrite, RD, WriteData); end
    tick;
    vectors++; if (Busy !== 4'b0000) begin miscompares++; $display("FAIL starve_busy: got %b required 0000", Busy); end
  endtask

  task automatic test_collision;
    idle();
    LdIssue = 1'b1; LdIssueRD = 2'd3;
    tick;
    LdIssue = 1'b0;
    tick;
    MemValid = 1'b1; MemRD = 2'd3; MemData = 16'hC0DE;
    expect_write(2'd3, 16'hC0DE, 1'b1);
    tick;
    MemValid = 1'b0;
    LdIssue = 1'b1; LdIssueRD = 2'd3;
    vectors++; if (RegWrite !== 1'b1 || RD !== 2'd3) begin miscompares++; $display("FAIL collide_write: got we=%b rd=%0d required 1/3", RegWrite, RD); end
    tick;
    LdIssue = 1'b0;
    vectors++; if (Busy !== 4'b1000) begin miscompares++; $display("FAIL collide_busy: got %b required 1000", Busy); end
`ifdef WB_STATS_EN
    vectors++; if (MemWbCount !== 16'(n_mem_exp)) begin miscompares++; $display("FAIL collide_memcount: got %0d required %0d", MemWbCount, n_mem_exp); end
    vectors++; if (AluWbCount !== 16'(n_alu_exp)) begin miscompares++; $display("FAIL collide_alucount: got %0d required %0d", AluWbCount, n_alu_exp); end
`endif
    MemValid = 1'b1; MemRD = 2'd3; MemData = 16'h3333;
    expect_write(2'd3, 16'h3333, 1'b1);
    tick;
    MemValid = 1'b0;
    tick;
    vectors++; if (Busy !== 4'b0000) begin miscompares++; $display("FAIL collide_drain: got %b required 0000", Busy); end
  endtask

  task automatic test_reset_mid;
    idle();
    LdIssue = 1'b1; LdIssueRD = 2'd1;
    tick;
    LdIssue = 1'b0;
    AluValid = 1'b1; AluRD = 2'd0; AluData = 16'h7777;
    expect_write(2'd0, 16'h7777, 1'b0);
    MemValid = 1'b1; MemRD = 2'd1; MemData = 16'h9999;
    tick;
    idle();
    Reset = 1'b1;
    tick;
    tick;
    vectors++; if (Busy !== 4'b0000) begin miscompares++; $display("FAIL midreset_busy: got %b required 0000", Busy); end
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL midreset_regwrite: got %b required 0", RegWrite); end
    vectors++; if (MemReady !== 1'b0) begin miscompares++; $display("FAIL midreset_memready: got %b required 0", MemReady); end
    Reset = 1'b0;
    #1;
    vectors++; if (MemReady !== 1'b1) begin miscompares++; $display("FAIL midreset_release: got %b required 1", MemReady); end
`ifdef WB_STATS_EN
    vectors++; if (AluWbCount !== 16'd0 || MemWbCount !== 16'd0) begin miscompares++; $display("FAIL midreset_counts: got %0d/%0d required 0/0", AluWbCount, MemWbCount); end
`endif
    for (int i = 0; i < 3; i++) tick;
    vectors++; if (RegWrite !== 1'b0 || Busy !== 4'b0000) begin miscompares++; $display("FAIL midreset_discard: got we=%b busy=%b required 0/0000", RegWrite, Busy); end
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    test_reset();
    test_alu_path();
    test_back_to_back();
    test_load_bypass();
    test_fifo_fill();
    test_starvation();
    test_collision();
    test_reset_mid();
    tick;
    tick;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes: got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
